// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with a selectable registered or first-word-fall-through read path,
// occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] AF_THR   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR   = PW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flagged: DEPTH must be a power of 2 and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_flagged: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flagged: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("sync_fifo_flagged: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [PW-1:0]         count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [PW-1:0]         wptr_nxt_s;
    logic [PW-1:0]         rptr_nxt_s;
    logic [PW-1:0]         count_nxt_s;
    logic                  full_nxt_s;
    logic                  empty_nxt_s;

    // Accept decisions use only registered flags, so a same-cycle read never frees room for a write.
    always_comb begin
        wr_acc_s = wr_en && !full_r;
        rd_acc_s = rd_en && !empty_r;
        if (wr_acc_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (rd_acc_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
        count_nxt_s = wptr_nxt_s - rptr_nxt_s;
        full_nxt_s  = (wptr_nxt_s[PW-1] != rptr_nxt_s[PW-1]) &&
                      (wptr_nxt_s[PW-2:0] == rptr_nxt_s[PW-2:0]);
        empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
    end

    // Pointer and status registers; flags are computed from next-state pointers so they move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r         <= {PW{1'b0}};
            rptr_r         <= {PW{1'b0}};
            count_r        <= {PW{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            wptr_r         <= wptr_nxt_s;
            rptr_r         <= rptr_nxt_s;
            count_r        <= count_nxt_s;
            full_r         <= full_nxt_s;
            empty_r        <= empty_nxt_s;
            almost_full_r  <= (count_nxt_s >= AF_THR);
            almost_empty_r <= (count_nxt_s <= AE_THR);
        end
    end

    // Sticky error flags: a new violation wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end else if (err_clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // Storage array; intentionally not reset, stale contents are unreachable after pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[AW-1:0]] <= wr_data;
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_data_r;
        logic                  rd_valid_r;

        // Registered read: head word captured on the accepting edge, valid for one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_r  <= {DATA_WIDTH{1'b0}};
                rd_valid_r <= 1'b0;
            end else if (rd_acc_s) begin
                rd_data_r  <= mem_r[rptr_r[AW-1:0]];
                rd_valid_r <= 1'b1;
            end else begin
                rd_data_r  <= rd_data_r;
                rd_valid_r <= 1'b0;
            end
        end

        assign rd_data  = rd_data_r;
        assign rd_valid = rd_valid_r;
    end else begin : g_fwft_read
        logic [DATA_WIDTH-1:0] rd_data_s;

        // Head of queue is presented directly; zero while empty so reset shows a clean bus at once.
        always_comb begin
            if (!empty_r) begin
                rd_data_s = mem_r[rptr_r[AW-1:0]];
            end else begin
                rd_data_s = {DATA_WIDTH{1'b0}};
            end
        end

        assign rd_data  = rd_data_s;
        assign rd_valid = !empty_r;
    end

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed scoreboard bench for sync_fifo_flagged: a registered-read instance and a FWFT instance.
module tb_sync_fifo_flagged;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, wr_en0, rd_en0, err_clr0;
    logic [7:0] wr_data0, rd_data0;
    logic       rd_valid0, full0, empty0, af0, ae0, ov0, un0;
    logic [3:0] count0;

    logic       rst1, wr_en1, rd_en1, err_clr1;
    logic [7:0] wr_data1, rd_data1;
    logic       rd_valid1, full1, empty1, af1, ae1, ov1, un1;
    logic [3:0] count1;

    sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) dut0 (
        .clk(clk), .rst(rst0), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ov0),
        .underflow(un0), .err_clr(err_clr0)
    );

    sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) dut1 (
        .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ov1),
        .underflow(un1), .err_clr(err_clr1)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; wr_en0 = 1'b0; rd_en0 = 1'b0; err_clr0 = 1'b0; wr_data0 = 8'h00;
        rst1 = 1'b1; wr_en1 = 1'b0; rd_en1 = 1'b0; err_clr1 = 1'b0; wr_data1 = 8'h00;
        tick();
        tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        // Reset then idle
        chk("rst_empty", empty0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_count", count0, 0);
        chk("rst_full", full0, 0);
        chk("rst_af", af0, 0);
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_rd_data", rd_data0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_un", un0, 0);

        // Fill with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            wr_en0 = 1'b1;
            wr_data0 = 8'((i + 1) * 17);
            q0.push_back(wr_data0);
            tick();
            chk("fill_count", count0, i + 1);
            chk("fill_af", af0, ((i + 1) >= 6) ? 1 : 0);
            chk("fill_ae", ae0, ((i + 1) <= 1) ? 1 : 0);
            chk("fill_full", full0, ((i + 1) == 8) ? 1 : 0);
            chk("fill_empty", empty0, 0);
        end

        // Write while full with a same-cycle read: write dropped, read accepted
        wr_en0 = 1'b1; wr_data0 = 8'hFF; rd_en0 = 1'b1;
        tick();
        exp_d = q0.pop_front();
        chk("ovf_flag", ov0, 1);
        chk("ovf_count", count0, 7);
        chk("ovf_full", full0, 0);
        chk("ovf_rd_valid", rd_valid0, 1);
        chk("ovf_rd_data", rd_data0, exp_d);
        wr_en0 = 1'b0; rd_en0 = 1'b0; err_clr0 = 1'b1;
        tick();
        err_clr0 = 1'b0;
        chk("ovf_clr", ov0, 0);
        chk("pulse_end", rd_valid0, 0);
        chk("rd_data_hold", rd_data0, exp_d);

        // Drain remaining seven words
        for (int i = 0; i < 7; i++) begin
            rd_en0 = 1'b1;
            tick();
            exp_d = q0.pop_front();
            chk("drain_valid", rd_valid0, 1);
            chk("drain_data", rd_data0, exp_d);
            chk("drain_count", count0, 6 - i);
        end
        rd_en0 = 1'b0;
        tick();
        chk("drain_valid_end", rd_valid0, 0);
        chk("drain_empty", empty0, 1);
        chk("drain_ae", ae0, 1);
        chk("drain_hold", rd_data0, 8'h88);

        // Underflow and its priority over err_clr
        rd_en0 = 1'b1;
        tick();
        chk("unf_flag", un0, 1);
        chk("unf_valid", rd_valid0, 0);
        chk("unf_count", count0, 0);
        err_clr0 = 1'b1;
        tick();
        chk("unf_set_beats_clr", un0, 1);
        rd_en0 = 1'b0;
        tick();
        chk("unf_clr", un0, 0);
        err_clr0 = 1'b0;

        // Read and write together while empty: write lands, read rejected
        rd_en0 = 1'b1; wr_en0 = 1'b1; wr_data0 = 8'h5A;
        q0.push_back(wr_data0);
        tick();
        rd_en0 = 1'b0; wr_en0 = 1'b0;
        chk("rw_empty_un", un0, 1);
        chk("rw_empty_count", count0, 1);
        chk("rw_empty_valid", rd_valid0, 0);
        chk("rw_empty_empty", empty0, 0);
        err_clr0 = 1'b1;
        tick();
        err_clr0 = 1'b0;
        chk("rw_empty_clr", un0, 0);

        // Steady streaming at occupancy 4 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            wr_en0 = 1'b1;
            wr_data0 = 8'(i + 1);
            q0.push_back(wr_data0);
            tick();
        end
        wr_en0 = 1'b0;
        chk("stream_pre_count", count0, 4);
        for (int i = 0; i < 20; i++) begin
            wr_en0 = 1'b1; rd_en0 = 1'b1;
            wr_data0 = 8'($urandom_range(0, 255));
            q0.push_back(wr_data0);
            tick();
            exp_d = q0.pop_front();
            chk("stream_count", count0, 4);
            chk("stream_valid", rd_valid0, 1);
            chk("stream_data", rd_data0, exp_d);
        end
        wr_en0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en0 = 1'b1;
            tick();
            exp_d = q0.pop_front();
            chk("stream_drain_data", rd_data0, exp_d);
        end
        rd_en0 = 1'b0;
        tick();
        chk("stream_empty", empty0, 1);

        // Asynchronous reset mid-burst, registered-read instance
        wr_data0 = 8'h31; wr_en0 = 1'b1;
        tick();
        tick();
        rd_en0 = 1'b1;
        tick();
        chk("mid0_pre_valid", rd_valid0, 1);
        #2;
        rst0 = 1'b1;
        #1;
        chk("mid0_count", count0, 0);
        chk("mid0_empty", empty0, 1);
        chk("mid0_full", full0, 0);
        chk("mid0_ae", ae0, 1);
        chk("mid0_af", af0, 0);
        chk("mid0_valid", rd_valid0, 0);
        chk("mid0_data", rd_data0, 0);
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        tick();
        rst0 = 1'b0;
        q0.delete();

        // FWFT instance: head visible without rd_en
        chk("fw_rst_empty", empty1, 1);
        chk("fw_rst_valid", rd_valid1, 0);
        chk("fw_rst_data", rd_data1, 0);
        wr_en1 = 1'b1; wr_data1 = 8'hA5;
        tick();
        wr_en1 = 1'b0;
        chk("fw_empty", empty1, 0);
        chk("fw_valid", rd_valid1, 1);
        chk("fw_data", rd_data1, 8'hA5);
        chk("fw_count", count1, 1);
        tick();
        chk("fw_data_hold", rd_data1, 8'hA5);
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        chk("fw_pop_empty", empty1, 1);
        chk("fw_pop_valid", rd_valid1, 0);

        for (int i = 0; i < 3; i++) begin
            wr_en1 = 1'b1;
            wr_data1 = 8'hB1 + 8'(i);
            q1.push_back(wr_data1);
            tick();
        end
        wr_en1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_d = q1.pop_front();
            chk("fw_head", rd_data1, exp_d);
            rd_en1 = 1'b1;
            tick();
        end
        rd_en1 = 1'b0;
        chk("fw_burst_empty", empty1, 1);

        // FWFT underflow with same-cycle write, then reset mid-burst
        rd_en1 = 1'b1; wr_en1 = 1'b1; wr_data1 = 8'hC1;
        tick();
        rd_en1 = 1'b0; wr_data1 = 8'hC2;
        chk("fw_un", un1, 1);
        chk("fw_un_count", count1, 1);
        tick();
        chk("fw_burst_count", count1, 2);
        #2;
        rst1 = 1'b1;
        #1;
        chk("mid1_empty", empty1, 1);
        chk("mid1_valid", rd_valid1, 0);
        chk("mid1_data", rd_data1, 0);
        chk("mid1_count", count1, 0);
        chk("mid1_ae", ae1, 1);
        chk("mid1_un", un1, 0);
        wr_en1 = 1'b0;
        tick();
        rst1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
